// File: rtl/hist_pkg.sv
// Shared definitions for the histogram controller slice.
//   - default geometry of the histogram RAM and drop counter
//   - host command encodings
//   - controller state encoding
package hist_pkg;

   localparam int BIN_ADDR_W_DEF = 7;
   localparam int COUNT_W_DEF    = 32;
   localparam int DROP_W_DEF     = 16;

   typedef enum logic [1:0] {
      CMD_STOP    = 2'b00,
      CMD_CLEAR   = 2'b01,
      CMD_START   = 2'b10,
      CMD_READOUT = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ACCUM,
      ST_DRAIN,
      ST_READ
   } state_e;

endpackage

// File: rtl/hist_bin_ram.sv
// Simple dual-port histogram RAM, inferred as block RAM.
//   clk    : clock
//   we     : write enable, waddr/wdata : write port
//   raddr  : read address, rdata : registered read data (1-cycle latency)
// A read and write to the same address in one cycle returns the old contents.
module hist_bin_ram #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/hist_ctrl.sv
// Histogram RAM controller: event accumulation (read-modify-write with
// write forwarding), full clear sweeps and valid/ready readout streaming.
//   clk, rst_n           : clock, synchronous active-low reset
//   cmd_valid, cmd       : host command strobe / code (STOP, CLEAR, START, READOUT)
//   busy, running        : status (CLEAR/DRAIN/READ, ACCUM)
//   evt_valid, evt_bin   : bin event input, no backpressure
//   rd_valid, rd_ready   : readout handshake
//   rd_bin, rd_data      : readout bin index and count, rd_last on final bin
//   overflow             : sticky bin saturation flag
//   drop_cnt             : saturating count of events seen outside ACCUM
module hist_ctrl
   import hist_pkg::*;
#(
   parameter int BIN_ADDR_W = BIN_ADDR_W_DEF,
   parameter int COUNT_W    = COUNT_W_DEF,
   parameter int DROP_W     = DROP_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   input  logic [1:0]            cmd,
   output logic                  busy,
   output logic                  running,
   input  logic                  evt_valid,
   input  logic [BIN_ADDR_W-1:0] evt_bin,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [BIN_ADDR_W-1:0] rd_bin,
   output logic [COUNT_W-1:0]    rd_data,
   output logic                  rd_last,
   output logic                  overflow,
   output logic [DROP_W-1:0]     drop_cnt
);

   localparam logic [BIN_ADDR_W-1:0] LAST_BIN = '1;

   state_e state, state_nxt, drain_to, drain_nxt;

   logic [BIN_ADDR_W-1:0] clr_addr;
   logic [BIN_ADDR_W:0]   fetch_addr;   // extra MSB marks "all bins fetched"
   logic                  p_valid;      // RMW read in flight
   logic                  f_valid;      // readout read in flight / held in RAM output
   logic [BIN_ADDR_W-1:0] raddr, rq_addr;
   logic [COUNT_W-1:0]    ram_rdata, cur, inc;
   logic                  sat;
   logic                  lw_valid;
   logic [BIN_ADDR_W-1:0] lw_bin;
   logic [COUNT_W-1:0]    lw_data;
   logic                  we;
   logic [BIN_ADDR_W-1:0] waddr;
   logic [COUNT_W-1:0]    wdata;
   logic                  fetch_en, out_load, issue;
   logic                  enter_clear, enter_drain;

   hist_bin_ram #(
      .ADDR_W(BIN_ADDR_W),
      .DATA_W(COUNT_W)
   ) u_ram (
      .clk  (clk),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .raddr(raddr),
      .rdata(ram_rdata)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_CLEAR: if (clr_addr == LAST_BIN) state_nxt = ST_IDLE;
         ST_IDLE:
            if (cmd_valid) begin
               unique case (cmd)
                  CMD_CLEAR:   state_nxt = ST_CLEAR;
                  CMD_START:   state_nxt = ST_ACCUM;
                  CMD_READOUT: state_nxt = ST_DRAIN;
                  default:     state_nxt = ST_IDLE;
               endcase
            end
         ST_ACCUM: if (cmd_valid && cmd != CMD_START) state_nxt = ST_DRAIN;
         ST_DRAIN: state_nxt = drain_to;
         ST_READ:
            if (cmd_valid && cmd == CMD_STOP)      state_nxt = ST_IDLE;
            else if (rd_valid && rd_ready && rd_last) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The command that causes DRAIN entry also picks where DRAIN exits to.
   always_comb begin
      unique case (cmd)
         CMD_STOP:  drain_nxt = ST_IDLE;
         CMD_CLEAR: drain_nxt = ST_CLEAR;
         default:   drain_nxt = ST_READ;
      endcase
   end

   assign enter_clear = (state_nxt == ST_CLEAR) && (state != ST_CLEAR);
   assign enter_drain = (state_nxt == ST_DRAIN) && (state != ST_DRAIN);

   // The last write may hit the address now presented on the RAM output
   // (read-old collision), so both RMW and readout take it from lw_*.
   assign cur = (lw_valid && lw_bin == rq_addr) ? lw_data : ram_rdata;
   assign sat = &cur;
   assign inc = sat ? cur : cur + 1'b1;

   // Readout prefetch: first read is issued in DRAIN so the output register
   // is loaded in the first READ cycle. A stalled word is re-read in place.
   assign fetch_en = (state == ST_READ) || (state == ST_DRAIN && drain_to == ST_READ);
   assign out_load = (state == ST_READ) && f_valid && (!rd_valid || rd_ready);
   assign issue    = fetch_en && !fetch_addr[BIN_ADDR_W] && (!f_valid || out_load);

   always_comb begin
      if (state == ST_ACCUM) raddr = evt_bin;
      else if (issue)        raddr = fetch_addr[BIN_ADDR_W-1:0];
      else                   raddr = rq_addr;
   end

   always_comb begin
      if (state == ST_CLEAR) begin
         we    = 1'b1;
         waddr = clr_addr;
         wdata = '0;
      end else begin
         we    = p_valid;
         waddr = rq_addr;
         wdata = inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_CLEAR;
         drain_to   <= ST_IDLE;
         busy       <= 1'b1;
         running    <= 1'b0;
         clr_addr   <= '0;
         fetch_addr <= '0;
         p_valid    <= 1'b0;
         f_valid    <= 1'b0;
         rq_addr    <= '0;
         lw_valid   <= 1'b0;
         lw_bin     <= '0;
         lw_data    <= '0;
         rd_valid   <= 1'b0;
         rd_bin     <= '0;
         rd_data    <= '0;
         rd_last    <= 1'b0;
         overflow   <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         state   <= state_nxt;
         busy    <= (state_nxt == ST_CLEAR) || (state_nxt == ST_DRAIN) || (state_nxt == ST_READ);
         running <= (state_nxt == ST_ACCUM);

         if (enter_clear)             clr_addr <= '0;
         else if (state == ST_CLEAR)  clr_addr <= clr_addr + 1'b1;

         if (enter_drain) begin
            drain_to   <= drain_nxt;
            fetch_addr <= '0;
         end else if (issue) begin
            fetch_addr <= fetch_addr + 1'b1;
         end

         rq_addr  <= raddr;
         p_valid  <= (state == ST_ACCUM) && evt_valid;
         lw_valid <= we;
         lw_bin   <= waddr;
         lw_data  <= wdata;

         f_valid <= (state_nxt == ST_READ) && (issue || (f_valid && !out_load));

         if (out_load) begin
            rd_bin  <= rq_addr;
            rd_data <= cur;
         end

         if (state_nxt != ST_READ) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
         end else if (out_load) begin
            rd_valid <= 1'b1;
            rd_last  <= (rq_addr == LAST_BIN);
         end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
         end

         if (enter_clear)            overflow <= 1'b0;
         else if (p_valid && sat)    overflow <= 1'b1;

         if (enter_clear)
            drop_cnt <= '0;
         else if (evt_valid && state != ST_ACCUM && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hist_ctrl.sv
module tb_hist_ctrl;
   import hist_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, cmd_valid, evt_valid, rd_ready;
   logic [1:0]  cmd;
   logic [6:0]  evt_bin;
   logic        busy, running, rd_valid, rd_last, overflow;
   logic [6:0]  rd_bin;
   logic [31:0] rd_data;
   logic [15:0] drop_cnt;

   // Second instance with narrow counters for saturation behaviour.
   logic        s_rst_n, s_cmd_valid, s_evt_valid, s_rd_ready;
   logic [1:0]  s_cmd;
   logic [6:0]  s_evt_bin;
   logic        s_busy, s_running, s_rd_valid, s_rd_last, s_overflow;
   logic [6:0]  s_rd_bin;
   logic [3:0]  s_rd_data;
   logic [15:0] s_drop_cnt;

   always #5 clk = ~clk;

   hist_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
      .busy(busy), .running(running), .evt_valid(evt_valid), .evt_bin(evt_bin),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bin(rd_bin), .rd_data(rd_data),
      .rd_last(rd_last), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   hist_ctrl #(.BIN_ADDR_W(7), .COUNT_W(4), .DROP_W(16)) u_sat (
      .clk(clk), .rst_n(s_rst_n), .cmd_valid(s_cmd_valid), .cmd(s_cmd),
      .busy(s_busy), .running(s_running), .evt_valid(s_evt_valid), .evt_bin(s_evt_bin),
      .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_bin(s_rd_bin), .rd_data(s_rd_data),
      .rd_last(s_rd_last), .overflow(s_overflow), .drop_cnt(s_drop_cnt)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: per-bin counts and dropped events.
   int unsigned mcnt [128];
   int unsigned mdrop;

   typedef struct {
      logic       cv;
      logic [1:0] c;
      logic       ev;
      logic [6:0] bin;
      logic       busy;
      logic       running;
      logic [15:0] drop;
   } vec_t;
   vec_t tbl [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      foreach (mcnt[i]) mcnt[i] = 0;
      mdrop = 0;
   endtask

   task automatic send_cmd(input logic [1:0] c);
      cmd_valid = 1'b1;
      cmd = c;
      step();
      cmd_valid = 1'b0;
   endtask

   // Single cycle with optional event; model updated by caller's knowledge of state.
   task automatic ev_cycle(input logic [6:0] b, input bit in_accum);
      evt_valid = 1'b1;
      evt_bin = b;
      if (in_accum) mcnt[b]++;
      else mdrop++;
      step();
      evt_valid = 1'b0;
   endtask

   task automatic wait_idle(input int exp_cycles);
      int n = 0;
      while (busy && n < 400) begin
         step();
         n++;
      end
      check("clear_len", n, exp_cycles);
   endtask

   // abort_kind: 0 none, 1 STOP at word abort_at, 2 reset at word abort_at
   task automatic readout(input int unsigned ready_pct, input int abort_at, input int abort_kind);
      int idx = 0;
      int cyc = 0;
      int bubbles = 0;
      bit held = 0;
      logic [6:0]  hb = '0;
      logic [31:0] hd = '0;
      logic        hl = 1'b0;
      rd_ready = 1'b0;
      send_cmd(CMD_READOUT);
      check("rd_lat_n1", rd_valid, 0);
      step();
      check("rd_lat_n2", rd_valid, 0);
      step();
      check("rd_lat_n3", rd_valid, 1);
      while (idx < 128 && cyc < 3000) begin
         if (abort_at >= 0 && idx == abort_at && rd_valid) begin
            rd_ready = 1'b0;
            if (abort_kind == 1) begin
               cmd_valid = 1'b1;
               cmd = CMD_STOP;
               step();
               cmd_valid = 1'b0;
               check("stop_rd_valid", rd_valid, 0);
               check("stop_busy", busy, 0);
               repeat (5) step();
               check("stop_quiet", rd_valid, 0);
            end else begin
               rst_n = 1'b0;
               step();
               rst_n = 1'b1;
               check("rst_rd_valid", rd_valid, 0);
               check("rst_busy", busy, 1);
               model_clear();
               wait_idle(128);
            end
            return;
         end
         if (held && rd_valid) begin
            check("hold_bin", rd_bin, hb);
            check("hold_data", rd_data, hd);
            check("hold_last", rd_last, hl);
         end
         rd_ready = ($urandom_range(99) < ready_pct);
         if (rd_valid) begin
            if (rd_ready) begin
               check("rd_bin", rd_bin, idx);
               check("rd_data", rd_data, mcnt[idx]);
               check("rd_last", rd_last, (idx == 127));
               idx++;
               held = 0;
            end else begin
               held = 1;
               hb = rd_bin;
               hd = rd_data;
               hl = rd_last;
            end
         end else begin
            held = 0;
            bubbles++;
         end
         step();
         cyc++;
      end
      rd_ready = 1'b0;
      check("rd_count", idx, 128);
      check("rd_end_valid", rd_valid, 0);
      check("rd_end_busy", busy, 0);
      if (ready_pct == 100) check("rd_bubbles", bubbles, 0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: timeout reached at %0t", $time);
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; evt_valid = 1'b0; evt_bin = '0; rd_ready = 1'b0;
      s_rst_n = 1'b0; s_cmd_valid = 1'b0; s_cmd = 2'b00; s_evt_valid = 1'b0; s_evt_bin = '0; s_rd_ready = 1'b0;

      //                cv    cmd          ev    bin   busy  run   drop
      tbl[0] = '{1'b0, CMD_STOP,    1'b1, 7'd5, 1'b0, 1'b0, 16'd1}; // IDLE event dropped
      tbl[1] = '{1'b1, CMD_STOP,    1'b0, 7'd0, 1'b0, 1'b0, 16'd1}; // STOP in IDLE: no effect
      tbl[2] = '{1'b1, CMD_START,   1'b1, 7'd5, 1'b0, 1'b1, 16'd2}; // accept-cycle event still IDLE
      tbl[3] = '{1'b1, CMD_START,   1'b1, 7'd5, 1'b0, 1'b1, 16'd2}; // START ignored in ACCUM
      tbl[4] = '{1'b1, CMD_CLEAR,   1'b1, 7'd5, 1'b1, 1'b0, 16'd2}; // to DRAIN, event counted
      tbl[5] = '{1'b1, CMD_START,   1'b1, 7'd6, 1'b1, 1'b0, 16'd0}; // DRAIN -> CLEAR zeroes drops
      tbl[6] = '{1'b1, CMD_READOUT, 1'b1, 7'd6, 1'b1, 1'b0, 16'd1}; // ignored in CLEAR, dropped

      // Reset values and initial clear sweep
      step(); step();
      check("rst_busy", busy, 1);
      check("rst_running", running, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_rd_bin", rd_bin, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop", drop_cnt, 0);
      rst_n = 1'b1;
      model_clear();
      wait_idle(128);
      readout(100, -1, 0);

      // Command acceptance table
      foreach (tbl[i]) begin
         cmd_valid = tbl[i].cv;
         cmd       = tbl[i].c;
         evt_valid = tbl[i].ev;
         evt_bin   = tbl[i].bin;
         step();
         cmd_valid = 1'b0;
         evt_valid = 1'b0;
         check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         check($sformatf("tbl%0d_running", i), running, tbl[i].running);
         check($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].drop);
      end
      model_clear();
      mdrop = 1;
      wait_idle(127);

      // Back-to-back same-bin events; last event rides with STOP
      send_cmd(CMD_START);
      check("accum_running", running, 1);
      repeat (5) ev_cycle(7'd3, 1);
      cmd_valid = 1'b1; cmd = CMD_STOP;
      ev_cycle(7'd4, 1);
      cmd_valid = 1'b0;
      check("drain_busy", busy, 1);
      check("drain_running", running, 0);
      step();
      check("idle_busy", busy, 0);
      readout(100, -1, 0);

      // Forwarding hazard pattern, then stalled readout
      send_cmd(CMD_START);
      ev_cycle(7'd9, 1);
      ev_cycle(7'd9, 1);
      ev_cycle(7'd10, 1);
      ev_cycle(7'd9, 1);
      send_cmd(CMD_STOP);
      step();
      readout(50, -1, 0);

      // Randomised accumulation against the model
      send_cmd(CMD_START);
      for (int k = 0; k < 400; k++) begin
         evt_valid = ($urandom_range(99) < 75);
         evt_bin = ($urandom_range(3) == 0) ? 7'($urandom_range(127)) : 7'(60 + $urandom_range(3));
         if (evt_valid) mcnt[evt_bin]++;
         step();
      end
      cmd_valid = 1'b1; cmd = CMD_STOP;
      ev_cycle(7'd61, 1);
      cmd_valid = 1'b0;
      ev_cycle(7'd61, 0);      // in DRAIN
      check("rand_drop", drop_cnt, mdrop);
      check("rand_overflow", overflow, 0);
      readout(70, -1, 0);

      // Drop counting and CLEAR
      send_cmd(CMD_CLEAR);
      model_clear();
      wait_idle(128);
      check("clr_drop", drop_cnt, 0);
      repeat (10) ev_cycle(7'($urandom_range(127)), 0);
      repeat (2) begin
         send_cmd(CMD_START);
         send_cmd(CMD_STOP);
         ev_cycle(7'd2, 0);
      end
      check("drop12", drop_cnt, 12);
      send_cmd(CMD_CLEAR);
      check("clr2_drop", drop_cnt, 0);
      check("clr2_overflow", overflow, 0);
      model_clear();
      wait_idle(128);

      // Readout aborts: STOP mid-stream, then reset mid-stream
      send_cmd(CMD_START);
      repeat (3) ev_cycle(7'd50, 1);
      send_cmd(CMD_STOP);
      step();
      readout(60, 20, 1);
      readout(100, 40, 2);
      check("post_rst_drop", drop_cnt, 0);
      readout(100, -1, 0);   // RAM was swept by the post-reset clear

      // Saturation on the 4-bit instance
      s_rst_n = 1'b1;
      n = 0;
      while (s_busy && n < 400) begin step(); n++; end
      check("sat_clear_len", n, 128);
      s_cmd_valid = 1'b1; s_cmd = CMD_START; step(); s_cmd_valid = 1'b0;
      s_evt_bin = 7'd0;
      s_evt_valid = 1'b1;
      repeat (17) step();
      s_evt_valid = 1'b0;
      s_cmd_valid = 1'b1; s_cmd = CMD_STOP; step(); s_cmd_valid = 1'b0;
      step();
      check("sat_overflow", s_overflow, 1);
      s_rd_ready = 1'b1;
      s_cmd_valid = 1'b1; s_cmd = CMD_READOUT; step(); s_cmd_valid = 1'b0;
      n = 0;
      while (!s_rd_valid && n < 10) begin step(); n++; end
      check("sat_rd_valid", s_rd_valid, 1);
      check("sat_rd_bin", s_rd_bin, 0);
      check("sat_rd_data", s_rd_data, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
